// File: rtl/cb8_nearest_search.sv
// Sequential nearest-codeword search over a small scalar codebook held in an external
// combinational ROM: one entry per cycle, reports nearest index and saturated |error|.
module cb8_nearest_search #(
    parameter int N           = 32,
    parameter int NUM_ENTRIES = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] x_in,
    output logic [3:0]   rom_addr,
    input  logic [N-1:0] rom_data,
    output logic         busy,
    output logic         done,
    output logic [3:0]   index_out,
    output logic [N-1:0] err_out
);

    // S_FINISH is the busy cycle after the last compare where the results are committed,
    // so they are already visible on the outputs during the done pulse.
    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_FINISH,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_ADDR = 4'(NUM_ENTRIES - 1);

    state_t       state_q, state_d;
    logic [N-1:0] x_q, x_d;
    logic [3:0]   addr_q, addr_d;
    logic [N:0]   best_err_q, best_err_d;
    logic [3:0]   best_idx_q, best_idx_d;
    logic [3:0]   index_q, index_d;
    logic [N-1:0] err_q, err_d;

    logic signed [N:0] diff;
    logic [N:0]        mag;

    // One extra bit keeps the difference of two N-bit signed values from wrapping.
    always_comb begin
        diff = $signed({x_q[N-1], x_q}) - $signed({rom_data[N-1], rom_data});
        mag  = diff[N] ? $unsigned(-diff) : $unsigned(diff);
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        addr_d     = addr_q;
        best_err_d = best_err_q;
        best_idx_d = best_idx_q;
        index_d    = index_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d        = x_in;
                    addr_d     = '0;
                    best_err_d = '1;
                    best_idx_d = '0;
                    state_d    = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (mag < best_err_q) begin
                    best_err_d = mag;
                    best_idx_d = addr_q;
                end
                if (addr_q == LAST_ADDR) begin
                    state_d = S_FINISH;
                end else begin
                    addr_d = addr_q + 4'd1;
                end
            end
            S_FINISH: begin
                index_d = best_idx_q;
                err_d   = best_err_q[N] ? '1 : best_err_q[N-1:0];
                state_d = S_DONE;
            end
            S_DONE: begin
                addr_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            addr_q     <= '0;
            best_err_q <= '0;
            best_idx_q <= '0;
            index_q    <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            addr_q     <= addr_d;
            best_err_q <= best_err_d;
            best_idx_q <= best_idx_d;
            index_q    <= index_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        busy      = (state_q == S_SEARCH) || (state_q == S_FINISH);
        done      = (state_q == S_DONE);
        rom_addr  = (state_q == S_SEARCH) ? addr_q : 4'd0;
        index_out = index_q;
        err_out   = err_q;
    end

endmodule

// File: tb/tb_cb8_nearest_search.sv
// Bench for cb8_nearest_search: directed vectors, a behavioural timing/result model
// checked every cycle, and hand-computed literal expectations at each done pulse.
module tb_cb8_nearest_search;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] x_in;
    logic [3:0]  rom_addr;
    logic [31:0] rom_data;
    logic        busy;
    logic        done;
    logic [3:0]  index_out;
    logic [31:0] err_out;

    int compared   = 0;
    int mismatched = 0;

    cb8_nearest_search #(.N(32), .NUM_ENTRIES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .x_in      (x_in),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .busy      (busy),
        .done      (done),
        .index_out (index_out),
        .err_out   (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Codebook ROM: 2500..3200 Hz in 100 Hz steps, Q15.16.
    always_comb begin
        rom_data = '0;
        if (rom_addr < 4'd8) rom_data = 32'((2500 + 100 * int'(rom_addr)) * 65536);
    end

    // Nearest entry by plain integer arithmetic; returns {index, saturated error}.
    function automatic logic [35:0] nearest(input logic [31:0] x);
        longint xs;
        longint best;
        longint a;
        logic [3:0] bi;
        logic [31:0] be;
        xs   = longint'($signed(x));
        best = 64'h7FFF_FFFF_FFFF_FFFF;
        bi   = 4'd0;
        for (int i = 0; i < 8; i++) begin
            a = xs - longint'((2500 + 100 * i) * 65536);
            if (a < 0) a = -a;
            if (a < best) begin
                best = a;
                bi   = 4'(i);
            end
        end
        be = (best > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : best[31:0];
        return {bi, be};
    endfunction

    // Model: m_cyc counts cycles since the accepting edge (0 = idle, 10 = done cycle).
    int          m_cyc = 0;
    logic [35:0] m_res = '0;
    logic [3:0]  m_idx = '0;
    logic [31:0] m_err = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_cyc <= 0;
            m_idx <= '0;
            m_err <= '0;
        end else if (m_cyc == 0) begin
            if (start) begin
                m_cyc <= 1;
                m_res <= nearest(x_in);
            end
        end else if (m_cyc == 9) begin
            m_cyc <= 10;
            m_idx <= m_res[35:32];
            m_err <= m_res[31:0];
        end else if (m_cyc == 10) begin
            m_cyc <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("busy", 64'(busy), 64'((m_cyc >= 1) && (m_cyc <= 9)));
        checkOutput("done", 64'(done), 64'(m_cyc == 10));
        checkOutput("index_out", 64'(index_out), 64'(m_idx));
        checkOutput("err_out", 64'(err_out), 64'(m_err));
        if (m_cyc <= 8)
            checkOutput("rom_addr", 64'(rom_addr), 64'((m_cyc == 0) ? 0 : m_cyc - 1));
    end

    // Called at posedge+2; start is sampled on the next rising edge.
    task automatic applyStimulus(input logic [31:0] x);
        start = 1'b1;
        x_in  = x;
        @(posedge clk);
        #2;
        start = 1'b0;
        x_in  = 32'h1234_5678;
    endtask

    task automatic waitDone(output int lat, output int busy_cnt, output bit seen);
        lat      = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cnt++;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL done_timeout: got no done, expected done within 30 cycles");
        end
    endtask

    task automatic runSearch(input logic [31:0] x, input logic [3:0] exp_idx, input logic [31:0] exp_err);
        int lat;
        int busy_cnt;
        bit seen;
        applyStimulus(x);
        waitDone(lat, busy_cnt, seen);
        if (seen) begin
            checkOutput("latency", 64'(lat), 64'd10);
            checkOutput("busy_cycles", 64'(busy_cnt), 64'd9);
            checkOutput("idx_literal", 64'(index_out), 64'(exp_idx));
            checkOutput("err_literal", 64'(err_out), 64'(exp_err));
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        int lat;
        int busy_cnt;
        int done_cnt;
        bit seen;

        rst   = 1'b1;
        start = 1'b0;
        x_in  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_addr", 64'(rom_addr), 64'd0);
        checkOutput("reset_idx", 64'(index_out), 64'd0);
        checkOutput("reset_err", 64'(err_out), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        runSearch(32'h0A50_0000, 4'd1, 32'h0028_0000);
        runSearch(32'h09F6_0000, 4'd0, 32'h0032_0000);
        runSearch(32'h0FA0_0000, 4'd7, 32'h0320_0000);
        runSearch(32'hFF9C_0000, 4'd0, 32'h0A28_0000);
        runSearch(32'h8000_0000, 4'd0, 32'h89C4_0000);

        // Second start three cycles into a search must be ignored.
        applyStimulus(32'h0A50_0000);
        repeat (2) @(posedge clk);
        #2;
        start = 1'b1;
        x_in  = 32'h0C80_0000;
        @(posedge clk);
        #2;
        start = 1'b0;
        waitDone(lat, busy_cnt, seen);
        if (seen) begin
            checkOutput("ignored_idx", 64'(index_out), 64'd1);
            checkOutput("ignored_err", 64'(err_out), 64'h0028_0000);
        end
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        checkOutput("single_done", 64'(done_cnt), 64'd0);
        @(posedge clk);
        #2;

        // Reset during search cycle 5 aborts with no done pulse.
        applyStimulus(32'h09F6_0000);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_idx", 64'(index_out), 64'd0);
        checkOutput("abort_err", 64'(err_out), 64'd0);
        checkOutput("abort_addr", 64'(rom_addr), 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        checkOutput("abort_no_done", 64'(done_cnt), 64'd0);
        @(posedge clk);
        #2;

        runSearch(32'h0C80_0000, 4'd7, 32'h0000_0000);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
